triumph_if_prefetch: RTL and testbench

// - Instruction-fetch stage with decoupled memory request/response, a parametrised prefetch FIFO and branch redirect.
// - Sits between the instruction memory (req/gnt/rvalid protocol) and the ID stage (valid/ready).
// - Adds backpressure, stall tolerance, flush-on-redirect and per-instruction PC tracking to the free-running fetch.

---
 rtl/triumph_if_prefetch.sv | 118 +++++++++++
 tb/tb_triumph_if_prefetch.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/triumph_if_prefetch.sv
// Instruction-fetch stage: credit-limited memory requests, prefetch FIFO, branch redirect with response discard.
// Optional fetch counter enabled by defining TRIUMPH_IF_PERF_CNT_EN (adds perf_fetch_cnt_o).
module triumph_if_prefetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        id_ready_i,
  output logic        instr_valid_id_o,
  output logic [31:0] instr_data_id_o,
  output logic [31:0] instr_pc_id_o
`ifdef TRIUMPH_IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt_o
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] fifo_cnt_q, out_q, disc_q;
  logic [CW-1:0] fifo_cnt_n, out_n, disc_n;
  logic [31:0]   addr_q, pc_q, data_last_q;
  logic          req_q;

  logic          hs, rsp_live, rsp_drop, push, pop, credit_n;
  logic [31:0]   target_aligned;
  logic          unused_target_lsb;

  assign unused_target_lsb = ^branch_target_i[1:0];
  assign target_aligned    = {branch_target_i[31:2], 2'b00};

  assign instr_req_o      = req_q & ~branch_i;
  assign instr_addr_o     = addr_q;
  assign instr_valid_id_o = (fifo_cnt_q != '0);
  assign instr_data_id_o  = instr_valid_id_o ? mem_q[rd_ptr_q] : data_last_q;
  assign instr_pc_id_o    = pc_q;

  always_comb begin
    hs       = instr_req_o & instr_gnt_i;
    rsp_live = instr_rvalid_i & (disc_q == '0);
    rsp_drop = instr_rvalid_i & (disc_q != '0);
    push     = rsp_live & ~branch_i;
    pop      = instr_valid_id_o & id_ready_i & ~branch_i;
    out_n      = out_q + CW'(hs) - CW'(rsp_live);
    disc_n     = disc_q - CW'(rsp_drop);
    fifo_cnt_n = fifo_cnt_q + CW'(push) - CW'(pop);
    // A redirect turns everything still in flight into responses to be thrown away
    if (branch_i) begin
      disc_n     = out_n + disc_n;
      out_n      = '0;
      fifo_cnt_n = '0;
    end
    credit_n = (out_n + disc_n + fifo_cnt_n) < DEPTH_C;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q       <= 1'b0;
      addr_q      <= RESET_PC;
      pc_q        <= RESET_PC;
      data_last_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      out_q       <= '0;
      disc_q      <= '0;
    end else begin
      req_q      <= credit_n;
      fifo_cnt_q <= fifo_cnt_n;
      out_q      <= out_n;
      disc_q     <= disc_n;
      if (branch_i) begin
        addr_q   <= target_aligned;
        pc_q     <= target_aligned;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (hs)   addr_q   <= addr_q + 32'd4;
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop) begin
          rd_ptr_q    <= rd_ptr_q + AW'(1);
          pc_q        <= pc_q + 32'd4;
          data_last_q <= mem_q[rd_ptr_q];
        end
      end
    end
  end

  // Storage needs no reset: entries are only visible once written
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= instr_rdata_i;
  end

`ifdef TRIUMPH_IF_PERF_CNT_EN
  logic [31:0] perf_q;
  assign perf_fetch_cnt_o = perf_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)    perf_q <= '0;
    else if (pop) perf_q <= perf_q + 32'd1;
  end
`endif

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(instr_rvalid_i && (disc_q == '0) && (fifo_cnt_q == DEPTH_C)));

endmodule

// File: tb/tb_triumph_if_prefetch.sv
// Randomized bench for triumph_if_prefetch against a queue-based model of the fetch stream.
// Perf counter checks are compiled in when TRIUMPH_IF_PERF_CNT_EN is defined.
module tb_triumph_if_prefetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req, gnt, rvalid, branch, ready, valid;
  logic [31:0] addr, rdata, target, data, pc;
`ifdef TRIUMPH_IF_PERF_CNT_EN
  logic [31:0] perf;
`endif

  triumph_if_prefetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_req_o(req), .instr_addr_o(addr), .instr_gnt_i(gnt),
    .instr_rvalid_i(rvalid), .instr_rdata_i(rdata),
    .branch_i(branch), .branch_target_i(target), .id_ready_i(ready),
    .instr_valid_id_o(valid), .instr_data_id_o(data), .instr_pc_id_o(pc)
`ifdef TRIUMPH_IF_PERF_CNT_EN
    , .perf_fetch_cnt_o(perf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; bit stale; } fl_t;
  fl_t         inflight[$];
  logic [31:0] buffered[$];
  logic [31:0] fetch_addr, exp_pc, last_data;
  logic [31:0] perf_exp;
  int          checks = 0;
  int          failures = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16] ^ ~a[15:0]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    inflight.delete();
    buffered.delete();
    fetch_addr = RESET_PC;
    exp_pc     = RESET_PC;
    last_data  = '0;
    perf_exp   = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    gnt = 0; rvalid = 0; rdata = '0; branch = 0; target = '0; ready = 0;
    model_reset();
    #1;
    check_eq("rst_req", {31'b0, req}, 32'd0);
    check_eq("rst_addr", addr, RESET_PC);
    check_eq("rst_valid", {31'b0, valid}, 32'd0);
    check_eq("rst_data", data, 32'd0);
    check_eq("rst_pc", pc, RESET_PC);
`ifdef TRIUMPH_IF_PERF_CNT_EN
    check_eq("rst_perf", perf, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cycle(input int p_gnt, input int p_rv, input int p_rdy, input int p_br,
                       input bit force_br, input logic [31:0] force_tgt);
    logic hs, pop, rv, br;
    logic [31:0] tgt, f_addr;
    fl_t f;
    @(negedge clk);
    gnt    = ($urandom_range(99) < p_gnt);
    rvalid = (inflight.size() > 0) && ($urandom_range(99) < p_rv);
    f_addr = (inflight.size() > 0) ? inflight[0].addr : 32'h0;
    rdata  = rvalid ? mem_word(f_addr) : $urandom;
    ready  = ($urandom_range(99) < p_rdy);
    branch = force_br || ($urandom_range(99) < p_br);
    if (force_br) target = force_tgt;
    else if ($urandom_range(9) == 0) target = 32'hFFFF_FFF0 | 32'($urandom_range(15));
    else target = 32'($urandom_range(4095));
    #1;
    check_eq("req", {31'b0, req},
             {31'b0, (!branch && (inflight.size() + buffered.size() < DEPTH))});
    check_eq("addr", addr, fetch_addr);
    check_eq("valid", {31'b0, valid}, {31'b0, (buffered.size() != 0)});
    check_eq("pc", pc, exp_pc);
    check_eq("data", data, (buffered.size() != 0) ? mem_word(buffered[0]) : last_data);
`ifdef TRIUMPH_IF_PERF_CNT_EN
    check_eq("perf", perf, perf_exp);
`endif
    hs  = req & gnt;
    pop = (buffered.size() != 0) && ready && !branch;
    rv  = rvalid;
    br  = branch;
    tgt = target;
    @(posedge clk);
    if (pop) begin
      last_data = mem_word(buffered[0]);
      void'(buffered.pop_front());
      exp_pc   = exp_pc + 32'd4;
      perf_exp = perf_exp + 32'd1;
    end
    if (rv) begin
      f = inflight.pop_front();
      if (!f.stale && !br) buffered.push_back(f.addr);
    end
    if (hs) begin
      inflight.push_back('{addr: fetch_addr, stale: 1'b0});
      fetch_addr = fetch_addr + 32'd4;
    end
    if (br) begin
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      buffered.delete();
      fetch_addr = {tgt[31:2], 2'b00};
      exp_pc     = {tgt[31:2], 2'b00};
    end
  endtask

  initial begin
    gnt = 0; rvalid = 0; rdata = '0; branch = 0; target = '0; ready = 0;
    model_reset();
    apply_reset();
    repeat (20) cycle(100, 100, 100, 0, 0, '0);   // streaming
    repeat (5)  cycle(0, 100, 100, 0, 0, '0);     // memory stalled
    repeat (30) cycle(100, 100, 0, 0, 0, '0);     // ID backpressure
    repeat (10) cycle(100, 100, 100, 0, 0, '0);
    repeat (2)  cycle(100, 0, 100, 0, 0, '0);     // build outstanding
    cycle(100, 0, 100, 0, 1, 32'h0000_0100);
    repeat (12) cycle(100, 100, 100, 0, 0, '0);
    cycle(100, 100, 100, 0, 1, 32'h0000_0203);
    repeat (8)  cycle(100, 100, 100, 0, 0, '0);
    cycle(100, 100, 100, 0, 1, 32'hFFFF_FFF4);    // address wrap
    repeat (10) cycle(100, 100, 100, 0, 0, '0);
    cycle(100, 100, 100, 0, 1, 32'h0000_0040);    // back-to-back redirects
    cycle(100, 100, 100, 0, 1, 32'h0000_0080);
    repeat (10) cycle(100, 60, 100, 0, 0, '0);
    repeat (200) cycle(60, 50, 60, 5, 0, '0);
    apply_reset();                                 // mid-operation reset
    repeat (2000) cycle(60, 50, 60, 5, 0, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
